me_search_engine: RTL and testbench

Parametrised full-search block-matching motion estimator, next generation of the fixed 16×16 estimator driven by the motion-estimation testbench. It reads an N×N reference block and an (N+2P)×(N+2P) search window from external synchronous ROMs. It computes the SAD of every candidate displacement in [-P,+P]² and reports the minimum distance and its motion vector. New over the fixed design: generic block size, search range and pixel width; a single search-memory port; optional early termination of hopeless candidates; a busy flag and restart-from-done.

---
 rtl/me_search_engine_pkg.sv | 34 +++
 rtl/me_search_engine_sad_acc.sv | 34 +++
 rtl/me_search_engine.sv | 160 ++++++++++++++++
 tb/tb_me_search_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_search_engine_pkg.sv
// Shared types and width/address helpers for the block-matching motion estimator.
package me_pkg;

    typedef enum logic [1:0] {
        ME_IDLE = 2'd0,
        ME_RUN  = 2'd1,
        ME_CMP  = 2'd2,
        ME_DONE = 2'd3
    } me_state_t;

    function automatic int unsigned dist_width(input int unsigned n, input int unsigned pw);
        return $clog2(n * n * ((32'd1 << pw) - 1) + 1);
    endfunction

    function automatic int unsigned vec_width(input int unsigned p);
        return $clog2(p + 1) + 1;
    endfunction

    function automatic int unsigned ref_addr_width(input int unsigned n);
        return $clog2(n * n);
    endfunction

    function automatic int unsigned srch_addr_width(input int unsigned n, input int unsigned p);
        return $clog2((n + 2 * p) * (n + 2 * p));
    endfunction

    // Displacements are carried as offsets dx+P / dy+P, so the window address stays unsigned.
    function automatic int unsigned disp_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned dx_off, input int unsigned dy_off,
                                              input int unsigned n, input int unsigned p);
        return (row + dy_off) * (n + 2 * p) + (col + dx_off);
    endfunction

endpackage

// File: rtl/me_search_engine_sad_acc.sv
// Absolute-difference accumulator with a one-cycle valid pipe matching the ROM read latency.
module me_sad_acc #(
    parameter int unsigned PW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue,
    input  logic          flush,
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] sad
);

    logic          valid;
    logic [PW-1:0] diff;

    always_comb begin
        diff = (a >= b) ? (a - b) : (b - a);
        sad  = acc + (valid ? DW'(diff) : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            acc   <= '0;
        end else begin
            valid <= issue & ~flush;
            acc   <= flush ? '0 : sad;
        end
    end

endmodule

// File: rtl/me_search_engine.sv
// Full-search motion estimator: walks every candidate in raster order and keeps the first minimum SAD.
module me_search_engine
    import me_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned P          = 8,
    parameter int unsigned PW         = 8,
    parameter int unsigned EARLY_TERM = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    output logic [ref_addr_width(N)-1:0]      AddressR,
    input  logic [PW-1:0]                     R,
    output logic [srch_addr_width(N, P)-1:0]  AddressS,
    input  logic [PW-1:0]                     S,
    output logic [dist_width(N, PW)-1:0]      BestDist,
    output logic [vec_width(P)-1:0]           motionX,
    output logic [vec_width(P)-1:0]           motionY,
    output logic                              busy,
    output logic                              completed
);

    localparam int unsigned DW  = dist_width(N, PW);
    localparam int unsigned VW  = vec_width(P);
    localparam int unsigned ARW = ref_addr_width(N);
    localparam int unsigned ASW = srch_addr_width(N, P);
    localparam int unsigned CW  = $clog2(N);
    localparam int unsigned OW  = $clog2(2 * P + 1);

    localparam logic [CW-1:0] LAST_RC  = CW'(N - 1);
    localparam logic [OW-1:0] LAST_OFF = OW'(2 * P);
    localparam logic [VW-1:0] P_V      = VW'(P);

    me_state_t     state;
    logic [CW-1:0] row, col;
    logic [OW-1:0] dx_off, dy_off;
    logic [OW-1:0] next_dx, next_dy;
    logic [DW-1:0] best_dist, acc, sad, final_dist;
    logic [VW-1:0] best_x, best_y, cur_x, cur_y, final_x, final_y;
    logic          last_pix, last_cand, abandon, better, run_issue, acc_flush;

    me_sad_acc #(
        .PW(PW),
        .DW(DW)
    ) u_acc (
        .clock(clock),
        .reset(reset),
        .issue(run_issue),
        .flush(acc_flush),
        .a    (R),
        .b    (S),
        .acc  (acc),
        .sad  (sad)
    );

    always_comb begin
        last_pix  = (row == LAST_RC) && (col == LAST_RC);
        last_cand = (dx_off == LAST_OFF) && (dy_off == LAST_OFF);
        // Partial SAD already at or above the best can never win a strict-less compare.
        abandon   = (EARLY_TERM != 0) && (state == ME_RUN) && (acc >= best_dist);
        better    = (state == ME_CMP) && (sad < best_dist);
        run_issue = (state == ME_RUN) && !abandon;
        acc_flush = (state != ME_RUN) || abandon;

        next_dx = (dx_off == LAST_OFF) ? '0 : dx_off + 1'b1;
        next_dy = (dx_off == LAST_OFF) ? dy_off + 1'b1 : dy_off;

        cur_x = VW'(dx_off) - P_V;
        cur_y = VW'(dy_off) - P_V;

        final_dist = better ? sad   : best_dist;
        final_x    = better ? cur_x : best_x;
        final_y    = better ? cur_y : best_y;

        busy      = (state == ME_RUN) || (state == ME_CMP);
        completed = (state == ME_DONE);

        AddressR = '0;
        AddressS = '0;
        if (state == ME_RUN) begin
            AddressR = ARW'(32'(row) * N + 32'(col));
            AddressS = ASW'(disp_addr(32'(row), 32'(col), 32'(dx_off), 32'(dy_off), N, P));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ME_IDLE;
            row       <= '0;
            col       <= '0;
            dx_off    <= '0;
            dy_off    <= '0;
            best_dist <= '0;
            best_x    <= '0;
            best_y    <= '0;
            BestDist  <= '0;
            motionX   <= '0;
            motionY   <= '0;
        end else begin
            case (state)
                ME_IDLE, ME_DONE: begin
                    if (start) begin
                        state     <= ME_RUN;
                        row       <= '0;
                        col       <= '0;
                        dx_off    <= '0;
                        dy_off    <= '0;
                        best_dist <= '1;
                        best_x    <= '0;
                        best_y    <= '0;
                    end
                end
                ME_RUN: begin
                    if (abandon) begin
                        row <= '0;
                        col <= '0;
                        if (last_cand) begin
                            state    <= ME_DONE;
                            BestDist <= final_dist;
                            motionX  <= final_x;
                            motionY  <= final_y;
                        end else begin
                            dx_off <= next_dx;
                            dy_off <= next_dy;
                        end
                    end else if (last_pix) begin
                        state <= ME_CMP;
                        row   <= '0;
                        col   <= '0;
                    end else if (col == LAST_RC) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                ME_CMP: begin
                    if (better) begin
                        best_dist <= sad;
                        best_x    <= cur_x;
                        best_y    <= cur_y;
                    end
                    if (last_cand) begin
                        state    <= ME_DONE;
                        BestDist <= final_dist;
                        motionX  <= final_x;
                        motionY  <= final_y;
                    end else begin
                        state  <= ME_RUN;
                        dx_off <= next_dx;
                        dy_off <= next_dy;
                    end
                end
                default: state <= ME_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_search_engine.sv
// Randomised bench: two estimators (early termination off/on) sharing ROM images, checked against a SAD model.
module tb_me_search_engine;

    localparam int N       = 4;
    localparam int P       = 2;
    localparam int PW      = 8;
    localparam int W       = N + 2 * P;
    localparam int NC      = 2 * P + 1;
    localparam int RUN_LAT = NC * NC * (N * N + 1) + 1;
    localparam int LIMIT   = 2000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;

    logic [3:0]  ar_ne, ar_et;
    logic [5:0]  as_ne, as_et;
    logic [7:0]  r_ne, s_ne, r_et, s_et;
    logic [11:0] bd_ne, bd_et;
    logic [2:0]  mx_ne, my_ne, mx_et, my_et;
    logic        busy_ne, busy_et, done_ne, done_et;
    logic [17:0] res_ne, res_et;

    logic [7:0] ref_mem [N*N];
    logic [7:0] win_mem [W*W];

    int total = 0;
    int bad   = 0;

    assign res_ne = {bd_ne, mx_ne, my_ne};
    assign res_et = {bd_et, mx_et, my_et};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_ne <= ref_mem[ar_ne];
        s_ne <= win_mem[as_ne];
        r_et <= ref_mem[ar_et];
        s_et <= win_mem[as_et];
    end

    me_search_engine #(.N(N), .P(P), .PW(PW), .EARLY_TERM(0)) dut_ne (
        .clock(clk), .reset(rst), .start(start),
        .AddressR(ar_ne), .R(r_ne), .AddressS(as_ne), .S(s_ne),
        .BestDist(bd_ne), .motionX(mx_ne), .motionY(my_ne),
        .busy(busy_ne), .completed(done_ne)
    );

    me_search_engine #(.N(N), .P(P), .PW(PW), .EARLY_TERM(1)) dut_et (
        .clock(clk), .reset(rst), .start(start),
        .AddressR(ar_et), .R(r_et), .AddressS(as_et), .S(s_et),
        .BestDist(bd_et), .motionX(mx_et), .motionY(my_et),
        .busy(busy_et), .completed(done_et)
    );

    // Exhaustive SAD over all displacements; first strict minimum in raster order wins.
    function automatic logic [17:0] model_result();
        int best, bx, by, sad, d;
        best = -1; bx = 0; by = 0;
        for (int dy = -P; dy <= P; dy++) begin
            for (int dx = -P; dx <= P; dx++) begin
                sad = 0;
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        d = int'(ref_mem[r*N+c]) - int'(win_mem[(r+dy+P)*W + c+dx+P]);
                        sad += (d < 0) ? -d : d;
                    end
                end
                if (best < 0 || sad < best) begin
                    best = sad; bx = dx; by = dy;
                end
            end
        end
        return {best[11:0], bx[2:0], by[2:0]};
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < N*N; i++)
            ref_mem[i] = (mode == 1) ? 8'h55 : (mode == 2) ? 8'hFF : 8'($urandom);
        for (int i = 0; i < W*W; i++)
            win_mem[i] = (mode == 1) ? 8'h55 : (mode == 2) ? 8'h00 : 8'($urandom);
    endtask

    task automatic plant(input int dx, input int dy);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                win_mem[(r+dy+P)*W + c+dx+P] = ref_mem[r*N+c];
    endtask

    // Starts both engines; tracks each until done, checking per-cycle addresses, busy and held outputs.
    task automatic do_run(input int pulse_at, output int lat_ne, output int lat_et, output int errs);
        logic [17:0] prev_ne, prev_et;
        logic [3:0]  exp_ar;
        logic [5:0]  exp_as;
        int cyc, j, cand, pix;
        prev_ne = res_ne; prev_et = res_et;
        lat_ne = 0; lat_et = 0; errs = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); cyc = 1;
        while ((lat_ne == 0 || lat_et == 0) && cyc < LIMIT) begin
            @(negedge clk);
            start = (pulse_at > 0 && cyc >= pulse_at && cyc < pulse_at + 4);
            if (lat_ne == 0) begin
                if (done_ne === 1'b1) lat_ne = cyc;
                else begin
                    j = cyc - 1; cand = j / (N*N+1); pix = j % (N*N+1);
                    exp_ar = '0; exp_as = '0;
                    if (pix < N*N) begin
                        exp_ar = 4'(pix);
                        exp_as = 6'((pix/N + cand/NC) * W + pix%N + cand%NC);
                    end
                    if (ar_ne !== exp_ar || as_ne !== exp_as || busy_ne !== 1'b1 || res_ne !== prev_ne)
                        errs++;
                end
            end
            if (lat_et == 0) begin
                if (done_et === 1'b1) lat_et = cyc;
                else if (busy_et !== 1'b1 || res_et !== prev_et) errs++;
            end
            @(posedge clk); cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({res_ne, busy_ne, done_ne, ar_ne, as_ne} !== '0) begin
            bad++; $display("FAIL reset_held_ne: got %h expected 0", {res_ne, busy_ne, done_ne, ar_ne, as_ne});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({res_et, busy_et, done_et, ar_et, as_et} !== '0) begin
            bad++; $display("FAIL reset_released_et: got %h expected 0", {res_et, busy_et, done_et, ar_et, as_et});
        end
    endtask

    task automatic test_planted();
        logic [17:0] expv;
        int lne, let_, errs;
        fill(0); plant(2, -1);
        expv = model_result();
        do_run(0, lne, let_, errs);
        total++;
        if (res_ne !== expv) begin bad++; $display("FAIL planted_ne: got %h expected %h", res_ne, expv); end
        total++;
        if (res_et !== expv) begin bad++; $display("FAIL planted_et: got %h expected %h", res_et, expv); end
        total++;
        if (lne !== RUN_LAT) begin bad++; $display("FAIL planted_latency: got %0d expected %0d", lne, RUN_LAT); end
        total++;
        if (let_ == 0 || let_ >= lne) begin
            bad++; $display("FAIL early_term_shorter: got %0d expected below %0d", let_, lne);
        end
        total++;
        if (errs !== 0) begin bad++; $display("FAIL planted_run_trace: got %0d errors expected 0", errs); end
    endtask

    task automatic test_uniform_and_max();
        logic [17:0] expv;
        int lne, let_, errs;
        for (int mode = 1; mode <= 2; mode++) begin
            fill(mode);
            expv = model_result();
            do_run(0, lne, let_, errs);
            total++;
            if (res_ne !== expv || res_et !== expv) begin
                bad++; $display("FAIL const_mode%0d: got %h/%h expected %h", mode, res_ne, res_et, expv);
            end
            total++;
            if (errs !== 0 || lne !== RUN_LAT || let_ == 0) begin
                bad++; $display("FAIL const_mode%0d_run: got errs=%0d lat=%0d/%0d expected 0/%0d", mode, errs, lne, let_, RUN_LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] expv;
        int lne, let_, errs;
        for (int it = 0; it < 3; it++) begin
            fill(0);
            expv = model_result();
            do_run(0, lne, let_, errs);
            total++;
            if (res_ne !== expv) begin bad++; $display("FAIL random%0d_ne: got %h expected %h", it, res_ne, expv); end
            total++;
            if (res_et !== expv || let_ == 0) begin
                bad++; $display("FAIL random%0d_et: got %h expected %h", it, res_et, expv);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [17:0] expv;
        int lne, let_, errs;
        fill(0); plant(-1, 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({res_ne, busy_ne, done_ne, ar_ne, as_ne} !== '0) begin
            bad++; $display("FAIL mid_reset_ne: got %h expected 0", {res_ne, busy_ne, done_ne, ar_ne, as_ne});
        end
        total++;
        if ({res_et, busy_et, done_et, ar_et, as_et} !== '0) begin
            bad++; $display("FAIL mid_reset_et: got %h expected 0", {res_et, busy_et, done_et, ar_et, as_et});
        end
        @(negedge clk); rst = 1'b0;
        expv = model_result();
        do_run(0, lne, let_, errs);
        total++;
        if (res_ne !== expv || res_et !== expv) begin
            bad++; $display("FAIL after_reset_result: got %h/%h expected %h", res_ne, res_et, expv);
        end
        total++;
        if (lne !== RUN_LAT || errs !== 0) begin
            bad++; $display("FAIL after_reset_run: got lat=%0d errs=%0d expected %0d/0", lne, errs, RUN_LAT);
        end
    endtask

    task automatic test_start_during_run();
        logic [17:0] expv;
        int lne, let_, errs;
        fill(0); plant(0, 2);
        expv = model_result();
        do_run(50, lne, let_, errs);
        total++;
        if (lne !== RUN_LAT) begin bad++; $display("FAIL start_ignored_latency: got %0d expected %0d", lne, RUN_LAT); end
        total++;
        if (res_ne !== expv || res_et !== expv || errs !== 0) begin
            bad++; $display("FAIL start_ignored_result: got %h/%h errs=%0d expected %h", res_ne, res_et, errs, expv);
        end
    endtask

    task automatic test_restart_from_done();
        logic [17:0] expv, held;
        int lne, let_, errs;
        held = res_ne;
        repeat (5) @(negedge clk);
        total++;
        if (done_ne !== 1'b1 || res_ne !== held || res_et !== held) begin
            bad++; $display("FAIL done_stable: got %h/%h done=%b expected %h", res_ne, res_et, done_ne, held);
        end
        fill(0); plant(-2, 0);
        expv = model_result();
        do_run(0, lne, let_, errs);
        total++;
        if (lne !== RUN_LAT || errs !== 0) begin
            bad++; $display("FAIL restart_run: got lat=%0d errs=%0d expected %0d/0", lne, errs, RUN_LAT);
        end
        total++;
        if (res_ne !== expv || res_et !== expv) begin
            bad++; $display("FAIL restart_result: got %h/%h expected %h", res_ne, res_et, expv);
        end
    endtask

    initial begin
        test_reset();
        test_planted();
        test_uniform_and_max();
        test_random();
        test_reset_mid_run();
        test_start_during_run();
        test_restart_from_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
